pf_iod_lvds_rx_word_align: RTL and testbench

- Fabric-side word aligner for the receive end of the 10:1 LVDS link.
- Sits between the RX IOD's 10-bit parallel RX_DATA output and user logic.
- Drives the IOD RX_BIT_SLIP input until the transmitter's training word appears at a fixed lane position, then declares lock and passes data through.

---
 rtl/pf_iod_lvds_rx_word_align.sv | 108 ++++++++++
 tb/tb_pf_iod_lvds_rx_word_align.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/pf_iod_lvds_rx_word_align.sv
// Word aligner for the 10:1 LVDS RX: pulses the IOD bit-slip until TRAIN_PATTERN repeats, then locks.
// RX_DATA_OUT has 1-cycle latency with no backpressure; status outputs trail the FSM state by one register.
module pf_iod_lvds_rx_word_align #(
   parameter int                    DATA_WIDTH    = 10,
   parameter logic [DATA_WIDTH-1:0] TRAIN_PATTERN = 10'h3F0,
   parameter int                    MATCH_COUNT   = 8,
   parameter int                    SETTLE_CYCLES = 4,
   parameter int                    MAX_SLIPS     = 9
) (
   input  logic                           FAB_CLK,
   input  logic                           RX_SYNC_RST,
   input  logic                           ALIGN_START,
   input  logic [DATA_WIDTH-1:0]          RX_DATA_0,
   output logic                           RX_BIT_SLIP,
   output logic [DATA_WIDTH-1:0]          RX_DATA_OUT,
   output logic                           RX_DATA_VALID,
   output logic                           ALIGN_LOCKED,
   output logic                           ALIGN_ERR,
   output logic [$clog2(MAX_SLIPS+1)-1:0] SLIP_CNT
);
   localparam int SW = $clog2(MAX_SLIPS+1);
   localparam int MW = $clog2(MATCH_COUNT+1);
   localparam int CW = $clog2(SETTLE_CYCLES+1);

   typedef enum logic [2:0] {IDLE, SETTLE, CHECK, SLIP, LOCKED, FAIL} state_t;

   state_t                state_q, state_d;
   logic [CW-1:0]         settle_q, settle_d;
   logic [MW-1:0]         match_q, match_d;
   logic [SW-1:0]         slip_q, slip_d;
   logic                  locked_q, locked_d;
   logic                  err_q, err_d;
   logic [DATA_WIDTH-1:0] data_q;

   always_ff @(posedge FAB_CLK) begin
      if (RX_SYNC_RST) begin
         state_q  <= IDLE;
         settle_q <= '0;
         match_q  <= '0;
         slip_q   <= '0;
         locked_q <= 1'b0;
         err_q    <= 1'b0;
         data_q   <= '0;
      end else begin
         state_q  <= state_d;
         settle_q <= settle_d;
         match_q  <= match_d;
         slip_q   <= slip_d;
         locked_q <= locked_d;
         err_q    <= err_d;
         data_q   <= RX_DATA_0;
      end
   end

   always_comb begin
      state_d  = state_q;
      settle_d = settle_q;
      match_d  = match_q;
      slip_d   = slip_q;
      case (state_q)
         IDLE: ;
         SETTLE: begin
            settle_d = settle_q - CW'(1);
            if (settle_q == CW'(1)) begin
               state_d = CHECK;
               match_d = '0;
            end
         end
         CHECK: begin
            if (RX_DATA_0 == TRAIN_PATTERN) begin
               match_d = match_q + MW'(1);
               if (match_q == MW'(MATCH_COUNT - 1))
                  state_d = LOCKED;
            end else begin
               match_d = '0;
               state_d = (slip_q == SW'(MAX_SLIPS)) ? FAIL : SLIP;
            end
         end
         SLIP: begin
            slip_d   = slip_q + SW'(1);
            settle_d = CW'(SETTLE_CYCLES);
            state_d  = SETTLE;
         end
         LOCKED: ;
         FAIL: ;
         default: state_d = IDLE;
      endcase

      // A restart overrides whatever the current state decided, including a slip in progress.
      if (ALIGN_START) begin
         state_d  = SETTLE;
         settle_d = CW'(SETTLE_CYCLES);
         match_d  = '0;
         slip_d   = '0;
      end

      locked_d = (state_q == LOCKED) && !ALIGN_START;
      err_d    = (err_q || (state_q == FAIL)) && !ALIGN_START;
   end

   assign RX_BIT_SLIP   = (state_q == SLIP);
   assign RX_DATA_OUT   = data_q;
   assign RX_DATA_VALID = locked_q;
   assign ALIGN_LOCKED  = locked_q;
   assign ALIGN_ERR     = err_q;
   assign SLIP_CNT      = slip_q;

endmodule

// File: tb/tb_pf_iod_lvds_rx_word_align.sv
// Bench for pf_iod_lvds_rx_word_align: vector table for reset/lock, link model for slip scenarios.
module tb_pf_iod_lvds_rx_word_align;
   localparam logic [9:0] TRAIN = 10'h3F0;

   logic       FAB_CLK = 1'b0;
   logic       RX_SYNC_RST;
   logic       ALIGN_START;
   logic [9:0] RX_DATA_0;
   logic       RX_BIT_SLIP;
   logic [9:0] RX_DATA_OUT;
   logic       RX_DATA_VALID;
   logic       ALIGN_LOCKED;
   logic       ALIGN_ERR;
   logic [3:0] SLIP_CNT;

   pf_iod_lvds_rx_word_align dut (
      .FAB_CLK      (FAB_CLK),
      .RX_SYNC_RST  (RX_SYNC_RST),
      .ALIGN_START  (ALIGN_START),
      .RX_DATA_0    (RX_DATA_0),
      .RX_BIT_SLIP  (RX_BIT_SLIP),
      .RX_DATA_OUT  (RX_DATA_OUT),
      .RX_DATA_VALID(RX_DATA_VALID),
      .ALIGN_LOCKED (ALIGN_LOCKED),
      .ALIGN_ERR    (ALIGN_ERR),
      .SLIP_CNT     (SLIP_CNT)
   );

   always #5 FAB_CLK = ~FAB_CLK;

   typedef struct {
      logic       rst;
      logic       start;
      logic [9:0] data;
      logic [7:0] exp;
   } vec_t;

   vec_t       tbl[20];
   logic [9:0] exp_q[$];
   int         total = 0;
   int         bad = 0;
   int         cyc = 0;
   int         n_slips = 0;
   int         last_slip = -100;
   int         rot = 0;
   logic       zero_mode = 1'b0;
   int         at;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [7:0] status();
      return {ALIGN_LOCKED, RX_DATA_VALID, ALIGN_ERR, RX_BIT_SLIP, SLIP_CNT};
   endfunction

   function automatic logic [9:0] rotl(input logic [9:0] w, input int r);
      logic [9:0] res;
      res = (w << r) | (w >> (10 - r));
      return res;
   endfunction

   function automatic logic [9:0] model();
      return zero_mode ? 10'h000 : rotl(TRAIN, rot);
   endfunction

   // One clock: scoreboard the registered data copy and track slip pulses in the link model.
   task automatic tick();
      exp_q.push_back(RX_SYNC_RST ? 10'h000 : RX_DATA_0);
      @(posedge FAB_CLK);
      #1;
      cyc++;
      chk("data_out", {22'd0, RX_DATA_OUT}, {22'd0, exp_q.pop_front()});
      if (RX_BIT_SLIP) begin
         if (n_slips > 0)
            chk("slip_spacing_ok", (cyc - last_slip) >= 6, 1);
         last_slip = cyc;
         n_slips++;
         if (rot > 0) rot--;
      end
   endtask

   task automatic start_seq();
      n_slips   = 0;
      last_slip = -100;
      ALIGN_START = 1'b1;
      RX_DATA_0   = model();
      tick();
      ALIGN_START = 1'b0;
   endtask

   // Returns the number of edges after the start edge at which lock or error appeared, -1 on timeout.
   task automatic run_until(input int bound, input int corrupt_at, output int when);
      when = -1;
      for (int i = 1; i <= bound; i++) begin
         RX_DATA_0 = (i == corrupt_at) ? ~TRAIN : model();
         tick();
         if (ALIGN_LOCKED || ALIGN_ERR) begin
            when = i;
            break;
         end
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      RX_SYNC_RST = 1'b1;
      ALIGN_START = 1'b0;
      RX_DATA_0   = 10'h000;

      // Reset (alone and with start), idle with random data, then aligned lock 13 edges after start.
      for (int i = 0; i < 20; i++) begin
         tbl[i].rst   = (i < 2);
         tbl[i].start = (i == 1) || (i == 5);
         tbl[i].data  = (i < 5) ? 10'($urandom) : TRAIN;
         tbl[i].exp   = (i >= 18) ? 8'hC0 : 8'h00;
      end
      for (int i = 0; i < 20; i++) begin
         RX_SYNC_RST = tbl[i].rst;
         ALIGN_START = tbl[i].start;
         RX_DATA_0   = tbl[i].data;
         tick();
         chk($sformatf("vec%0d", i), {24'd0, status()}, {24'd0, tbl[i].exp});
      end
      RX_SYNC_RST = 1'b0;
      ALIGN_START = 1'b0;

      // Restart while locked: valid drops on the start edge, relock 13 edges later.
      rot = 0;
      start_seq();
      chk("restart_drops_valid", {24'd0, status()}, 32'h00);
      run_until(100, 0, at);
      chk("relock_cycle", at, 13);
      chk("relock_status", {24'd0, status()}, 32'hC0);
      chk("relock_slips", n_slips, 0);

      // Idle after reset never slips, whatever the data.
      RX_SYNC_RST = 1'b1;
      tick();
      RX_SYNC_RST = 1'b0;
      n_slips = 0;
      for (int i = 0; i < 30; i++) begin
         RX_DATA_0 = 10'($urandom);
         tick();
      end
      chk("idle_slips", n_slips, 0);
      chk("idle_status", {24'd0, status()}, 32'h00);

      // Link rotated by 3: three slips, each adding 6 cycles before lock.
      rot = 3;
      start_seq();
      run_until(200, 0, at);
      chk("rot3_lock_cycle", at, 31);
      chk("rot3_slips", n_slips, 3);
      chk("rot3_status", {24'd0, status()}, 32'hC3);

      // Dead link: nine slips, then sticky error with no further slipping.
      zero_mode = 1'b1;
      start_seq();
      run_until(200, 0, at);
      chk("fail_cycle", at, 60);
      for (int i = 0; i < 20; i++) begin
         RX_DATA_0 = model();
         tick();
      end
      chk("fail_slips", n_slips, 9);
      chk("fail_status", {24'd0, status()}, 32'h29);
      ALIGN_START = 1'b1;
      tick();
      ALIGN_START = 1'b0;
      chk("start_clears_err", {24'd0, status()}, 32'h00);
      zero_mode = 1'b0;

      // One corrupted word on the 5th check cycle forces a single slip and a fresh match count.
      rot = 0;
      start_seq();
      run_until(200, 9, at);
      chk("corrupt_lock_cycle", at, 23);
      chk("corrupt_slips", n_slips, 1);
      chk("corrupt_status", {24'd0, status()}, 32'hC1);

      // Reset together with start while locked: everything clears and stays idle.
      RX_SYNC_RST = 1'b1;
      ALIGN_START = 1'b1;
      tick();
      RX_SYNC_RST = 1'b0;
      ALIGN_START = 1'b0;
      chk("rst_start_status", {24'd0, status()}, 32'h00);
      n_slips = 0;
      for (int i = 0; i < 20; i++) begin
         RX_DATA_0 = TRAIN;
         tick();
      end
      chk("rst_start_idle", {24'd0, status()}, 32'h00);

      // Reset in the middle of settling returns to idle; aligned data alone does not lock.
      start_seq();
      for (int i = 0; i < 2; i++) begin
         RX_DATA_0 = TRAIN;
         tick();
      end
      RX_SYNC_RST = 1'b1;
      tick();
      RX_SYNC_RST = 1'b0;
      chk("mid_settle_rst", {24'd0, status()}, 32'h00);
      for (int i = 0; i < 20; i++) begin
         RX_DATA_0 = TRAIN;
         tick();
      end
      chk("mid_settle_idle", {24'd0, status()}, 32'h00);
      chk("mid_settle_slips", n_slips, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
